// File: rtl/trigger_capture_if.sv
// Sample-stream, trigger-control and waveform-RAM write bus for trigger_capture.
interface trigger_capture_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 10
);
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic [DATA_W-1:0] trig_level;
   logic              trig_slope;
   logic              arm;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] start_addr;
   logic [1:0]        state;
   logic              done;
   logic              auto_fired;

   modport master (
      output sample_in, sample_valid, trig_level, trig_slope, arm,
      input  wr_en, wr_addr, wr_data, start_addr, state, done, auto_fired
   );

   modport slave (
      input  sample_in, sample_valid, trig_level, trig_slope, arm,
      output wr_en, wr_addr, wr_data, start_addr, state, done, auto_fired
   );
endinterface

// File: rtl/trigger_capture.sv
// Hysteresis level trigger writing one pre/post-trigger frame into a circular RAM.
// Define AUTO_TRIG_EN to add the forced-trigger timeout (AUTO_TIMEOUT valid samples in ARMED).
module trigger_capture #(
   parameter int DATA_W  = 12,
   parameter int ADDR_W  = 10,
   parameter int PRETRIG = 128,
   parameter int HYST    = 16
`ifdef AUTO_TRIG_EN
   ,
   parameter int AUTO_TIMEOUT = 4096
`endif
) (
   input logic              clk,
   input logic              reset,
   trigger_capture_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRETRIG);
   localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRETRIG - 1);
   localparam logic [ADDR_W-1:0] POST_N   = ADDR_W'(DEPTH - PRETRIG - 1);
   localparam logic [DATA_W:0]   HYST_X   = (DATA_W+1)'(HYST);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_PREFILL = 2'b01,
      S_ARMED   = 2'b10,
      S_POST    = 2'b11
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_pre_cnt;
   logic [ADDR_W-1:0] r_post_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_start_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_wr_en;
   logic              r_done;
   logic              r_flag;

   logic [DATA_W:0]   w_lo_x;
   logic [DATA_W:0]   w_hi_x;
   logic [DATA_W-1:0] w_lo;
   logic [DATA_W-1:0] w_hi;
   logic              w_flag_set;
   logic              w_level_hit;
   logic              w_real_trig;
   logic              w_trig;
   logic              w_write;

`ifdef AUTO_TRIG_EN
   localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

   logic [AUTO_W-1:0] r_auto_cnt;
   logic              r_auto_fired;
   logic              w_force;
`endif

   always_comb begin
      // Thresholds computed one bit wider so the band saturates instead of wrapping.
      w_lo_x = {1'b0, bus.trig_level} - HYST_X;
      w_hi_x = {1'b0, bus.trig_level} + HYST_X;
      w_lo   = w_lo_x[DATA_W] ? '0 : w_lo_x[DATA_W-1:0];
      w_hi   = w_hi_x[DATA_W] ? '1 : w_hi_x[DATA_W-1:0];
      if (bus.trig_slope) begin
         w_flag_set  = bus.sample_in > w_hi;
         w_level_hit = bus.sample_in <= bus.trig_level;
      end else begin
         w_flag_set  = bus.sample_in < w_lo;
         w_level_hit = bus.sample_in >= bus.trig_level;
      end
      w_real_trig = r_flag && w_level_hit;
`ifdef AUTO_TRIG_EN
      w_force = !w_real_trig && (r_auto_cnt == AUTO_LAST);
      w_trig  = w_real_trig || w_force;
`else
      w_trig  = w_real_trig;
`endif
      w_write = bus.sample_valid && !bus.arm &&
                ((r_state == S_PREFILL) || (r_state == S_ARMED) ||
                 ((r_state == S_POST) && !r_done && (r_post_cnt != '0)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_pre_cnt    <= '0;
         r_post_cnt   <= '0;
         r_wr_addr    <= '0;
         r_start_addr <= '0;
         r_wr_data    <= '0;
         r_wr_en      <= 1'b0;
         r_done       <= 1'b0;
         r_flag       <= 1'b0;
`ifdef AUTO_TRIG_EN
         r_auto_cnt   <= '0;
         r_auto_fired <= 1'b0;
`endif
      end else begin
         r_wr_en <= w_write;
         if (w_write) begin
            r_wr_addr <= r_wptr;
            r_wr_data <= bus.sample_in;
            r_wptr    <= r_wptr + ONE_A;
         end
         if (bus.arm) begin
            r_state   <= S_PREFILL;
            r_pre_cnt <= '0;
            r_flag    <= 1'b0;
            r_done    <= 1'b0;
`ifdef AUTO_TRIG_EN
            r_auto_cnt   <= '0;
            r_auto_fired <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_PREFILL: begin
                  if (bus.sample_valid) begin
                     r_pre_cnt <= r_pre_cnt + ONE_A;
                     if (r_pre_cnt == PRE_LAST) r_state <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (bus.sample_valid) begin
                     if (w_flag_set) r_flag <= 1'b1;
`ifdef AUTO_TRIG_EN
                     r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
`endif
                     if (w_trig) begin
                        r_state      <= S_POST;
                        r_start_addr <= r_wptr - PRE_A;
                        r_post_cnt   <= POST_N;
`ifdef AUTO_TRIG_EN
                        r_auto_cnt   <= '0;
                        r_auto_fired <= w_force;
`endif
                     end
                  end
               end
               S_POST: begin
                  // done rises the cycle after the final write strobe is presented
                  if (!r_done) begin
                     if (r_post_cnt == '0) r_done <= 1'b1;
                     else if (bus.sample_valid) r_post_cnt <= r_post_cnt - ONE_A;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.start_addr = r_start_addr;
   assign bus.state      = r_state;
   assign bus.done       = r_done;
`ifdef AUTO_TRIG_EN
   assign bus.auto_fired = r_auto_fired;
`else
   assign bus.auto_fired = 1'b0;
`endif

endmodule
